// File: rtl/wb_arbiter_rr_wdt.sv
// Round-robin Wishbone classic arbiter with locked-cycle grants and a
// bus watchdog that aborts a stalled strobe and returns ERR to its master.
module wb_arbiter_rr_wdt #(
    parameter int PORTS        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORTS*ADDR_WIDTH-1:0]     wbm_adr_i,
    input  logic [PORTS*DATA_WIDTH-1:0]     wbm_dat_i,
    output logic [DATA_WIDTH-1:0]           wbm_dat_o,
    input  logic [PORTS-1:0]                wbm_we_i,
    input  logic [PORTS*SELECT_WIDTH-1:0]   wbm_sel_i,
    input  logic [PORTS-1:0]                wbm_stb_i,
    input  logic [PORTS-1:0]                wbm_cyc_i,
    output logic [PORTS-1:0]                wbm_ack_o,
    output logic [PORTS-1:0]                wbm_err_o,
    output logic [PORTS-1:0]                wbm_rty_o,
    output logic [ADDR_WIDTH-1:0]           wbs_adr_o,
    output logic [DATA_WIDTH-1:0]           wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
    output logic                            wbs_we_o,
    output logic [SELECT_WIDTH-1:0]         wbs_sel_o,
    output logic                            wbs_stb_o,
    output logic                            wbs_cyc_o,
    input  logic                            wbs_ack_i,
    input  logic                            wbs_err_i,
    input  logic                            wbs_rty_i,
    output logic [PORTS-1:0]                grant_o,
    output logic                            timeout_o,
    output logic [$clog2(PORTS)-1:0]        timeout_port_o
);

    localparam int IW = $clog2(PORTS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
    localparam logic [PORTS-1:0] ONE = {{(PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ABORT
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [PORTS-1:0] grant_q;
    logic [CW-1:0]   cnt_q;
    logic            to_q;
    logic [IW-1:0]   to_port_q;
    logic            err_pulse_q;

    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            found;
    logic            in_grant;
    logic            owner_cyc;
    logic            owner_stb;
    logic            term;
    logic            wdt_fire;

    logic [ADDR_WIDTH-1:0]   adr_a [PORTS];
    logic [DATA_WIDTH-1:0]   dat_a [PORTS];
    logic [SELECT_WIDTH-1:0] sel_a [PORTS];

    for (genvar g = 0; g < PORTS; g++) begin : g_split
        assign adr_a[g] = wbm_adr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_a[g] = wbm_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign sel_a[g] = wbm_sel_i[g*SELECT_WIDTH +: SELECT_WIDTH];
    end

    // Search upward from the last owner so it gets lowest priority
    always_comb begin
        win   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = IW'((int'(ptr_q) + i) % PORTS);
            if (!found && wbm_cyc_i[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign in_grant  = (state_q == GRANT);
    assign owner_cyc = wbm_cyc_i[ptr_q];
    assign owner_stb = wbm_stb_i[ptr_q];
    assign term      = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign wdt_fire  = (TIMEOUT > 0) && owner_stb && !term && (cnt_q == TLIM);

    assign wbs_cyc_o = in_grant;
    assign wbs_stb_o = in_grant & owner_stb;
    assign wbs_we_o  = in_grant & wbm_we_i[ptr_q];
    assign wbs_adr_o = in_grant ? adr_a[ptr_q] : '0;
    assign wbs_dat_o = in_grant ? dat_a[ptr_q] : '0;
    assign wbs_sel_o = in_grant ? sel_a[ptr_q] : '0;

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = (in_grant & wbs_ack_i) ? grant_q : '0;
    assign wbm_rty_o = (in_grant & wbs_rty_i) ? grant_q : '0;
    assign wbm_err_o = ((in_grant & wbs_err_i) ? grant_q : '0)
                     | (err_pulse_q ? grant_q : '0);

    assign grant_o        = grant_q;
    assign timeout_o      = to_q;
    assign timeout_port_o = to_port_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(PORTS - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            to_q        <= 1'b0;
            to_port_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            to_q        <= 1'b0;
            err_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        ptr_q   <= win;
                        grant_q <= ONE << win;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_cyc) begin
                        grant_q <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (wdt_fire) begin
                        to_q        <= 1'b1;
                        to_port_q   <= ptr_q;
                        err_pulse_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ABORT;
                    end else if (owner_stb && !term) begin
                        if (cnt_q != TLIM)
                            cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                ABORT: begin
                    // Late slave terminations are dropped until the owner lets go
                    if (!owner_cyc) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr_wdt.sv
// Bench for wb_arbiter_rr_wdt: cycle-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_arbiter_rr_wdt;

    localparam int P  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk;
    logic            rst;
    logic [P*AW-1:0] m_adr;
    logic [P*DW-1:0] m_dat;
    logic [DW-1:0]   m_rdat;
    logic [P-1:0]    m_we;
    logic [P*SW-1:0] m_sel;
    logic [P-1:0]    m_stb;
    logic [P-1:0]    m_cyc;
    logic [P-1:0]    ack_o;
    logic [P-1:0]    err_o;
    logic [P-1:0]    rty_o;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_we;
    logic [SW-1:0]   s_sel;
    logic            s_stb;
    logic            s_cyc;
    logic            s_ack;
    logic            s_err;
    logic            s_rty;
    logic [P-1:0]    grant;
    logic            tout;
    logic [1:0]      tport;

    wb_arbiter_rr_wdt #(
        .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .SELECT_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(m_rdat),
        .wbm_we_i(m_we), .wbm_sel_i(m_sel), .wbm_stb_i(m_stb),
        .wbm_cyc_i(m_cyc), .wbm_ack_o(ack_o), .wbm_err_o(err_o),
        .wbm_rty_o(rty_o), .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o),
        .wbs_dat_i(s_dat_i), .wbs_we_o(s_we), .wbs_sel_o(s_sel),
        .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc), .wbs_ack_i(s_ack),
        .wbs_err_i(s_err), .wbs_rty_i(s_rty), .grant_o(grant),
        .timeout_o(tout), .timeout_port_o(tport)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: owner (-1 idle), aborted flag, last winner,
    // consecutive stalled-strobe cycles, pending abort pulse.
    int mo = -1;
    bit mab = 0;
    int mlast = P - 1;
    int mst = 0;
    bit mpl = 0;
    int mtp = 0;

    function automatic int pick(input int last, input logic [P-1:0] c);
        for (int i = 1; i <= P; i++)
            if (c[(last + i) % P]) return (last + i) % P;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mo <= -1; mab <= 0; mlast <= P - 1;
            mst <= 0; mpl <= 0; mtp <= 0;
        end else begin
            mpl <= 0;
            if (mo < 0) begin
                if (|m_cyc) begin
                    mo    <= pick(mlast, m_cyc);
                    mlast <= pick(mlast, m_cyc);
                    mst   <= 0;
                end
            end else if (mab) begin
                if (!m_cyc[mo]) begin
                    mo <= -1; mab <= 0;
                end
            end else if (!m_cyc[mo]) begin
                mo <= -1; mst <= 0;
            end else if (m_stb[mo] && !(s_ack | s_err | s_rty)) begin
                if (TO > 0 && mst == TO) begin
                    mab <= 1; mpl <= 1; mtp <= mo; mst <= 0;
                end else begin
                    mst <= (mst < TO) ? mst + 1 : mst;
                end
            end else begin
                mst <= 0;
            end
        end
    end

    int           om;
    logic         act;
    logic [P-1:0] eg;
    logic [P-1:0] ee;

    always @(negedge clk) begin
        if (chk_en) begin
            om  = (mo < 0) ? 0 : mo;
            act = (mo >= 0) && !mab;
            eg  = (mo >= 0) ? (P'(1) << mo) : '0;
            ee  = ((act && s_err) ? eg : '0) | (mpl ? (P'(1) << mtp) : '0);
            chk("grant", grant, eg);
            chk("wbs_cyc", s_cyc, act);
            chk("wbs_stb", s_stb, act && m_stb[om]);
            chk("wbs_we", s_we, act && m_we[om]);
            chk("wbs_adr", s_adr, act ? m_adr[om*AW +: AW] : '0);
            chk("wbs_dat", s_dat_o, act ? m_dat[om*DW +: DW] : '0);
            chk("wbs_sel", s_sel, act ? m_sel[om*SW +: SW] : '0);
            chk("ack", ack_o, (act && s_ack) ? eg : '0);
            chk("rty", rty_o, (act && s_rty) ? eg : '0);
            chk("err", err_o, ee);
            chk("tout", tout, mpl);
            chk("tport", tport, 2'(mtp));
            chk("rdat", m_rdat, s_dat_i);
        end
    end

    task automatic wait_grant(output int o);
        o = -1;
        for (int n = 0; n < 20; n++) begin
            if (grant != 0) break;
            step();
        end
        chk("wait_grant", grant != 0, 1);
        for (int i = 0; i < P; i++)
            if (grant[i]) o = i;
    endtask

    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int o;

    initial begin
        rst = 1;
        m_cyc = '0; m_stb = '0; m_we = 4'b1010;
        for (int i = 0; i < P; i++) begin
            m_adr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 16);
            m_dat[i*DW +: DW] = 32'hD000_0000 + 32'(i);
            m_sel[i*SW +: SW] = 4'(i + 3);
        end
        s_dat_i = 32'h1234_5678;
        s_ack = 0; s_err = 0; s_rty = 0;
        step();
        chk_en = 1;
        step();
        chk("rst_grant", grant, 0);
        chk("rst_cyc", s_cyc, 0);
        chk("rst_tout", tout, 0);
        chk("rst_tport", tport, 0);

        // All four masters request from reset
        rst = 0;
        m_cyc = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_grant(o);
            order.push_back(o);
            step();
            step();
            m_cyc[o] = 0;
            step();
            chk("t1_dead", grant, 0);
            if (k == 4) m_cyc = '0;
            else m_cyc[o] = 1;
        end
        for (int k = 0; k < 5; k++)
            chk("t1_order", order[k], exp_order[k]);
        step();
        step();

        // Port 2 alone, acked at t3
        s_dat_i = 32'hCAFE_F00D;
        m_cyc[2] = 1; m_stb[2] = 1;
        step();
        chk("t2_grant", grant, 4'b0100);
        chk("t2_stb", s_stb, 1);
        step();
        step();
        s_ack = 1;
        @(negedge clk);
        chk("t2_ack", ack_o, 4'b0100);
        step();
        s_ack = 0; m_stb[2] = 0; m_cyc[2] = 0;
        @(negedge clk);
        chk("t2_ack_gone", ack_o, 0);
        step();
        step();

        // Port 1 stalls until the watchdog fires
        m_cyc[1] = 1; m_stb[1] = 1;
        for (int k = 0; k < 9; k++) step();
        @(negedge clk);
        chk("t3_pre_err", err_o, 0);
        chk("t3_pre_tout", tout, 0);
        chk("t3_pre_cyc", s_cyc, 1);
        step();
        @(negedge clk);
        chk("t3_err", err_o, 4'b0010);
        chk("t3_tout", tout, 1);
        chk("t3_tport", tport, 1);
        chk("t3_cyc", s_cyc, 0);
        step();
        @(negedge clk);
        chk("t3_err_once", err_o, 0);
        chk("t3_tout_once", tout, 0);
        chk("t3_tport_hold", tport, 1);
        step();
        s_ack = 1;
        @(negedge clk);
        chk("t3_late_ack", ack_o, 0);
        step();
        s_ack = 0; m_cyc[1] = 0; m_stb[1] = 0;
        step();
        step();

        // Ack on the cycle the count reaches TIMEOUT
        m_cyc[0] = 1; m_stb[0] = 1;
        for (int k = 0; k < 9; k++) step();
        s_ack = 1;
        @(negedge clk);
        chk("t4_ack", ack_o, 4'b0001);
        step();
        s_ack = 0; m_stb[0] = 0; m_cyc[0] = 0;
        @(negedge clk);
        chk("t4_tout", tout, 0);
        chk("t4_err", err_o, 0);
        chk("t4_cyc", s_cyc, 1);
        step();
        step();

        // Port 3 owns, port 0 waits
        m_cyc[3] = 1;
        step();
        chk("t5_own", grant, 4'b1000);
        step();
        m_cyc[0] = 1; m_stb[3] = 1; s_err = 1;
        @(negedge clk);
        chk("t5_err_route", err_o, 4'b1000);
        step();
        s_err = 0; m_stb[3] = 0;
        @(negedge clk);
        chk("t5_hold", grant, 4'b1000);
        step();
        m_cyc[3] = 0;
        @(negedge clk);
        chk("t5_hold2", grant, 4'b1000);
        step();
        chk("t5_dead", grant, 0);
        chk("t5_dead_cyc", s_cyc, 0);
        step();
        chk("t5_next", grant, 4'b0001);
        m_cyc[0] = 0;
        step();
        step();

        // Reset during a stalled strobe
        m_cyc[2] = 1; m_stb[2] = 1;
        step();
        chk("t6_grant", grant, 4'b0100);
        step();
        step();
        step();
        rst = 1;
        step();
        chk("t6_grant0", grant, 0);
        chk("t6_cyc0", s_cyc, 0);
        chk("t6_err0", err_o, 0);
        chk("t6_tout0", tout, 0);
        rst = 0;
        m_cyc[0] = 1;
        step();
        chk("t6_first", grant, 4'b0001);
        m_cyc = '0; m_stb = '0;
        step();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule
